// File: rtl/accumulator_datapath_pkg.sv
// Shared definitions for the accumulator datapath and its controller:
// op codes, control-word field positions and status-vector bit positions.
package accumulator_datapath_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_PASS = 3'b101,
      OP_SHL  = 3'b110,
      OP_ASR  = 3'b111
   } op_e;

   localparam int CTRL_WIDTH  = 5;
   localparam int CTRL_OP_HI  = 4;
   localparam int CTRL_OP_LO  = 2;
   localparam int CTRL_LDB    = 1;
   localparam int CTRL_COMMIT = 0;

   localparam int VZ_V = 1;
   localparam int VZ_Z = 0;

   // The controller builds its output words with this helper so both sides agree on the layout
   function automatic logic [CTRL_WIDTH-1:0] build_ctrl(input op_e op, input logic ld_b,
                                                        input logic commit);
      logic [CTRL_WIDTH-1:0] word;
      word = '0;
      word[CTRL_OP_HI:CTRL_OP_LO] = op;
      word[CTRL_LDB]              = ld_b;
      word[CTRL_COMMIT]           = commit;
      return word;
   endfunction

endpackage

// File: rtl/accumulator_datapath_if.sv
// Bus between the processor controller (master) and the accumulator datapath (slave).
interface accumulator_datapath_if #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
);
   import accumulator_datapath_pkg::*;

   logic                  start;
   logic [CTRL_WIDTH-1:0] ctrl;
   logic [WIDTH-1:0]      data_in;
   logic [1:0]            vz;
   logic [WIDTH-1:0]      acc_out;
   logic [CNT_WIDTH-1:0]  commit_cnt;

   modport master (
      output start, ctrl, data_in,
      input  vz, acc_out, commit_cnt
   );

   modport slave (
      input  start, ctrl, data_in,
      output vz, acc_out, commit_cnt
   );

endinterface

// File: rtl/accumulator_alu.sv
// Purely combinational ALU of the accumulator datapath: computes the result,
// the signed-overflow flag and the zero flag for one op on (a, b).
module accumulator_alu
   import accumulator_datapath_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r,
   output logic             v,
   output logic             z
);

   // Result and overflow per op; overflow only exists for ADD, SUB and SHL
   always_comb begin
      r = a;
      v = 1'b0;
      case (op)
         OP_NOP:  r = a;
         OP_ADD: begin
            r = a + b;
            v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            r = a - b;
            v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_PASS: r = b;
         OP_SHL: begin
            r = {a[WIDTH-2:0], 1'b0};
            v = a[WIDTH-1] ^ a[WIDTH-2];
         end
         OP_ASR:  r = {a[WIDTH-1], a[WIDTH-1:1]};
         default: r = a;
      endcase
   end

   assign z = (r == '0);

endmodule

// File: rtl/accumulator_datapath.sv
// Accumulator datapath: decodes the controller word every cycle, updates the
// accumulator, operand register B, the registered {V,Z} status and a count of
// committed operations. All outputs come straight from registers.
module accumulator_datapath
   import accumulator_datapath_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input logic                  clock,
   input logic                  clear,
   accumulator_datapath_if.slave bus
);

   logic [WIDTH-1:0]     acc;
   logic [WIDTH-1:0]     b_reg;
   logic [1:0]           vz_reg;
   logic [CNT_WIDTH-1:0] cnt;

   op_e              op;
   logic             ld_b;
   logic             commit;
   logic [WIDTH-1:0] alu_r;
   logic             alu_v;
   logic             alu_z;

   assign op     = op_e'(bus.ctrl[CTRL_OP_HI:CTRL_OP_LO]);
   assign ld_b   = bus.ctrl[CTRL_LDB];
   assign commit = bus.ctrl[CTRL_COMMIT];

   accumulator_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op (op),
      .a  (acc),
      .b  (b_reg),
      .r  (alu_r),
      .v  (alu_v),
      .z  (alu_z)
   );

   // State update: clear/start wipe everything, otherwise commit and B-load act independently
   always_ff @(posedge clock) begin
      if (clear || bus.start) begin
         acc    <= '0;
         b_reg  <= '0;
         vz_reg <= 2'b00;
         cnt    <= '0;
      end else begin
         if (commit) begin
            acc            <= alu_r;
            vz_reg[VZ_V]   <= alu_v;
            vz_reg[VZ_Z]   <= alu_z;
            cnt            <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if (ld_b) begin
            b_reg <= bus.data_in;
         end
      end
   end

   assign bus.acc_out    = acc;
   assign bus.vz         = vz_reg;
   assign bus.commit_cnt = cnt;

endmodule
